// File: rtl/arb_req_queue_if.sv
// Client/arbiter bundle for the two-client request queue front-end.
// Latency: none, wires only.
// Backpressure: o_ready_* toward clients, o_req_*/i_gnt_* toward the arbiter.
interface arb_req_queue_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    // client 0 write side
    logic              i_push_0;
    logic [DATA_W-1:0] i_data_0;
    logic              o_ready_0;
    // client 1 write side
    logic              i_push_1;
    logic [DATA_W-1:0] i_data_1;
    logic              o_ready_1;
    // arbiter loop
    logic              o_req_0;
    logic              o_req_1;
    logic              i_gnt_0;
    logic              i_gnt_1;
    // shared output bus and status
    logic              o_valid;
    logic              o_src;
    logic [DATA_W-1:0] o_data;
    logic [CNT_W-1:0]  o_count_0;
    logic [CNT_W-1:0]  o_count_1;
    logic              o_err;

    // the queue block itself
    modport slave (
        input  i_push_0, i_data_0, i_push_1, i_data_1, i_gnt_0, i_gnt_1,
        output o_ready_0, o_ready_1, o_req_0, o_req_1,
               o_valid, o_src, o_data, o_count_0, o_count_1, o_err
    );

    // clients plus arbiter driving the queue block
    modport master (
        output i_push_0, i_data_0, i_push_1, i_data_1, i_gnt_0, i_gnt_1,
        input  o_ready_0, o_ready_1, o_req_0, o_req_1,
               o_valid, o_src, o_data, o_count_0, o_count_1, o_err
    );
endinterface

// File: rtl/arb_req_queue.sv
// Two independent client FIFOs feeding a shared, source-tagged output bus on arbiter grant.
// Latency: a grant popping in cycle N presents the word on o_data in cycle N+1.
// Backpressure: o_ready_k low while queue k is full; pushes then are dropped and flag o_err.
module arb_req_queue #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    arb_req_queue_if.slave bus
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ZERO_CNT = '0;

    // storage and per-queue state, index 0/1 = client
    logic [DATA_W-1:0] mem_q    [2][DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q [2];
    logic [PTR_W-1:0]  wr_ptr_d [2];
    logic [PTR_W-1:0]  rd_ptr_q [2];
    logic [PTR_W-1:0]  rd_ptr_d [2];
    logic [CNT_W-1:0]  cnt_q    [2];
    logic [CNT_W-1:0]  cnt_d    [2];

    // ready is held low until the first clock after reset release
    logic              rdy_en_q;

    // output stage
    logic              valid_q, valid_d;
    logic              src_q, src_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              err_q, err_d;

    // flattened request view
    logic [1:0]        push_req;
    logic [1:0]        gnt;
    logic [1:0]        ready;
    logic [1:0]        push_ok;
    logic [1:0]        push_drop;
    logic [1:0]        pop;
    logic [DATA_W-1:0] wr_data [2];
    logic [DATA_W-1:0] head    [2];

    assign push_req   = {bus.i_push_1, bus.i_push_0};
    assign gnt        = {bus.i_gnt_1, bus.i_gnt_0};
    assign wr_data[0] = bus.i_data_0;
    assign wr_data[1] = bus.i_data_1;

    // queue control: accept, drop and pop decisions plus next pointer/count values
    always_comb begin
        for (int k = 0; k < 2; k++) begin
            ready[k]     = rdy_en_q && (cnt_q[k] != FULL_CNT);
            push_ok[k]   = push_req[k] && ready[k];
            push_drop[k] = push_req[k] && (cnt_q[k] == FULL_CNT);
            head[k]      = mem_q[k][rd_ptr_q[k]];
        end
        // queue 0 wins an illegal dual grant; stale grants on empty queues do nothing
        pop[0] = gnt[0] && (cnt_q[0] != ZERO_CNT);
        pop[1] = gnt[1] && (cnt_q[1] != ZERO_CNT) && !gnt[0];

        for (int k = 0; k < 2; k++) begin
            wr_ptr_d[k] = push_ok[k] ? wr_ptr_q[k] + PTR_W'(1) : wr_ptr_q[k];
            rd_ptr_d[k] = pop[k]     ? rd_ptr_q[k] + PTR_W'(1) : rd_ptr_q[k];
            unique case ({push_ok[k], pop[k]})
                2'b10:   cnt_d[k] = cnt_q[k] + CNT_W'(1);
                2'b01:   cnt_d[k] = cnt_q[k] - CNT_W'(1);
                default: cnt_d[k] = cnt_q[k];
            endcase
        end
    end

    // output stage next state: tag and capture the popped head, hold otherwise
    always_comb begin
        valid_d = pop[0] || pop[1];
        src_d   = src_q;
        data_d  = data_q;
        if (pop[0]) begin
            src_d  = 1'b0;
            data_d = head[0];
        end else if (pop[1]) begin
            src_d  = 1'b1;
            data_d = head[1];
        end
        err_d = err_q || (|push_drop) || (gnt[0] && gnt[1]);
    end

    // FIFO storage: written on accepted push, contents need no reset
    always_ff @(posedge i_clk) begin
        for (int k = 0; k < 2; k++) begin
            if (push_ok[k]) begin
                mem_q[k][wr_ptr_q[k]] <= wr_data[k];
            end
        end
    end

    // pointer and occupancy registers for both queues
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < 2; k++) begin
                wr_ptr_q[k] <= '0;
                rd_ptr_q[k] <= '0;
                cnt_q[k]    <= '0;
            end
            rdy_en_q <= 1'b0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                wr_ptr_q[k] <= wr_ptr_d[k];
                rd_ptr_q[k] <= rd_ptr_d[k];
                cnt_q[k]    <= cnt_d[k];
            end
            rdy_en_q <= 1'b1;
        end
    end

    // registered output bus and sticky error flag
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_q <= 1'b0;
            src_q   <= 1'b0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            src_q   <= src_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    assign bus.o_ready_0 = ready[0];
    assign bus.o_ready_1 = ready[1];
    assign bus.o_req_0   = (cnt_q[0] != ZERO_CNT);
    assign bus.o_req_1   = (cnt_q[1] != ZERO_CNT);
    assign bus.o_count_0 = cnt_q[0];
    assign bus.o_count_1 = cnt_q[1];
    assign bus.o_valid   = valid_q;
    assign bus.o_src     = src_q;
    assign bus.o_data    = data_q;
    assign bus.o_err     = err_q;
endmodule
